i2s_master_ctrl: RTL and testbench

Master-mode I2S frame controller for the audio path. It generates BCLK and LRCLK from the system clock and sequences each stereo frame. It accepts one left/right 24-bit sample pair per frame over a valid/ready handshake and shifts it out MSB-first on `sdout`. It captures the codec's `sdin` into a left/right pair with a one-cycle `rx_valid` strobe. The DSP core sits on the sample side; the codec pins sit on the serial side.

---
 rtl/i2s_master_ctrl.sv | 140 ++++++++++++++
 tb/tb_i2s_master_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_master_ctrl.sv
// Master-mode I2S frame controller: derives BCLK/LRCLK from clk, shifts one
// stereo pair out per frame on sdout and assembles the codec's sdin into rx pairs.
module i2s_master_ctrl #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              underrun,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdout,
  input  logic              sdin
);

  localparam int PH_N  = 2 * BCLK_DIV;
  localparam int PH_W  = $clog2(PH_N);
  localparam int POS_N = 2 * SLOT_W;
  localparam int POS_W = $clog2(POS_N);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(PH_N - 1);
  localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(BCLK_DIV);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(BCLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(POS_N - 1);
  localparam logic [POS_W-1:0] L_FIRST   = POS_W'(1);
  localparam logic [POS_W-1:0] L_LAST    = POS_W'(DATA_W);
  localparam logic [POS_W-1:0] R_SLOT    = POS_W'(SLOT_W);
  localparam logic [POS_W-1:0] R_FIRST   = POS_W'(SLOT_W + 1);
  localparam logic [POS_W-1:0] R_LAST    = POS_W'(SLOT_W + DATA_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [2*DATA_W-1:0] tx_shift;
  logic [2*DATA_W-1:0] rx_shift;
  logic               running;
  logic               run_d;
  logic               at_t0;

  function automatic logic in_data(input logic [POS_W-1:0] pos);
    return ((pos >= L_FIRST) && (pos <= L_LAST)) ||
           ((pos >= R_FIRST) && (pos <= R_LAST));
  endfunction

  // The current cycle belongs to a live frame only if this edge keeps us in RUN.
  assign running = (state_q == RUN) && en;
  assign run_d   = (state_d == RUN);
  assign at_t0   = (phase_q == '0) && (pos_q == '0);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    phase_d = '0;
    pos_d   = '0;
    case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (phase_q == PH_LAST) begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
          phase_d = phase_q + PH_W'(1);
          pos_d   = pos_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
    end
  end

  // Outputs are registered from the next-cycle counters so they line up with t.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      sdout    <= 1'b0;
      tx_ready <= 1'b0;
      underrun <= 1'b0;
      rx_valid <= 1'b0;
      rx_left  <= '0;
      rx_right <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      bclk     <= run_d && (phase_d >= PH_HALF);
      lrclk    <= run_d && (pos_d >= R_SLOT);
      tx_ready <= run_d && (phase_d == '0) && (pos_d == '0);
      underrun <= 1'b0;
      rx_valid <= 1'b0;

      if (running && at_t0) begin
        tx_shift <= tx_valid ? {tx_left, tx_right} : '0;
        underrun <= !tx_valid;
      end else if (run_d && (phase_d == '0) && in_data(pos_d)) begin
        tx_shift <= {tx_shift[2*DATA_W-2:0], 1'b0};
      end

      if (!run_d) begin
        sdout <= 1'b0;
      end else if (phase_d == '0) begin
        sdout <= in_data(pos_d) ? tx_shift[2*DATA_W-1] : 1'b0;
      end

      // sdin is taken on the clk edge that raises bclk.
      if (running && (phase_q == PH_SAMPLE) && in_data(pos_q)) begin
        rx_shift <= {rx_shift[2*DATA_W-2:0], sdin};
        if (pos_q == R_LAST) begin
          {rx_left, rx_right} <= {rx_shift[2*DATA_W-2:0], sdin};
          rx_valid            <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Loopback bench: frame-level reference model checks the pins every cycle and a
// scoreboard queue checks each received pair against the pair sent that frame.
module tb_i2s_master_ctrl;

  localparam int DW    = 24;
  localparam int SW    = 32;
  localparam int BD    = 4;
  localparam int FRAME = 2 * SW * 2 * BD;
  localparam int RXV_T = (SW + DW) * 2 * BD + BD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] tx_left = '0;
  logic [DW-1:0] tx_right = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, underrun, rx_valid, bclk, lrclk, sdout, sdin;
  logic [DW-1:0] rx_left, rx_right;

  assign sdin = sdout;

  i2s_master_ctrl #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .underrun(underrun),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .bclk(bclk), .lrclk(lrclk), .sdout(sdout), .sdin(sdin)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position t and the pair latched at this frame's start.
  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  bit            m_run = 1'b0;
  int            m_t = 0;
  logic [DW-1:0] m_l = '0;
  logic [DW-1:0] m_r = '0;
  bit            m_under = 1'b0;
  pair_t         sb_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst || !en) begin
      m_run = 1'b0;
      m_t   = 0;
      sb_q.delete();
    end else begin
      if (m_run && m_t == 0) begin
        m_l     = tx_valid ? tx_left : '0;
        m_r     = tx_valid ? tx_right : '0;
        m_under = !tx_valid;
        sb_q.push_back('{m_l, m_r});
      end
      m_t   = m_run ? (m_t + 1) % FRAME : 0;
      m_run = 1'b1;
    end
  end

  function automatic logic exp_sd(input int t);
    int p;
    p = t / (2 * BD);
    if (p >= 1 && p <= DW) return m_l[DW-p];
    if (p >= SW + 1 && p <= SW + DW) return m_r[SW+DW-p];
    return 1'b0;
  endfunction

  always @(negedge clk) begin : pin_check
    logic [5:0] e;
    if (m_run)
      e = {(m_t % (2 * BD)) >= BD, m_t >= FRAME / 2, exp_sd(m_t),
           m_t == 0, m_t == 1 && m_under, m_t == RXV_T};
    else
      e = '0;
    check($sformatf("pins{bclk,lrclk,sdout,tx_ready,underrun,rx_valid} t=%0d", m_t),
          64'({bclk, lrclk, sdout, tx_ready, underrun, rx_valid}), 64'(e));
  end

  always @(negedge clk) begin : rx_monitor
    pair_t p;
    if (rx_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: rx_valid with no pending pair at %0t", $time);
      end else begin
        p = sb_q.pop_front();
        check("rx_left", 64'(rx_left), 64'(p.l));
        check("rx_right", 64'(rx_right), 64'(p.r));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (!(m_run && m_t == target)) begin
      step();
      n++;
      if (n > 2 * FRAME) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_t: t=%0d not reached within %0d cycles", target, n);
        return;
      end
    end
  endtask

  task automatic set_tx(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic v);
    tx_left  = l;
    tx_right = r;
    tx_valid = v;
  endtask

  task automatic next_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic v);
    step();
    wait_t(1);
    set_tx(l, r, v);
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  initial begin
    set_tx(24'hA55A01, 24'h123456, 1'b1);
    repeat (3) step();
    @(negedge clk);
    check("reset_pins", 64'({bclk, lrclk, sdout, tx_ready, underrun, rx_valid}), 64'(0));
    check("reset_rx_left", 64'(rx_left), 64'(0));
    check("reset_rx_right", 64'(rx_right), 64'(0));
    rst = 1'b0;
    step();
    en = 1'b1;

    // Frame 0 carries the loopback pair; frame 1 the bit-order pattern; frame 2 underruns.
    wait_t(1);
    set_tx(24'h800001, rnd(), 1'b1);
    next_frame(rnd(), rnd(), 1'b0);
    for (int i = 0; i < 4; i++)
      next_frame(rnd(), rnd(), $urandom_range(0, 4) != 0);

    // Abort mid-frame, then restart a full frame.
    step();
    wait_t(300);
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    @(negedge clk);
    check("tx_ready_after_reenable", 64'(tx_ready), 64'(1));
    wait_t(RXV_T + 2);

    // Asynchronous reset mid-frame.
    set_tx(rnd(), rnd(), 1'b1);
    wait_t(100);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_pins", 64'({bclk, lrclk, sdout, tx_ready, underrun, rx_valid}), 64'(0));
    check("midframe_reset_rx_left", 64'(rx_left), 64'(0));
    check("midframe_reset_rx_right", 64'(rx_right), 64'(0));
    rst = 1'b0;
    step();
    @(negedge clk);
    check("tx_ready_after_reset", 64'(tx_ready), 64'(1));
    wait_t(RXV_T + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
